// File: rtl/core_ifq.sv
// Instruction fetch queue between fetch and decode.
// Buffers completed fetches {pc, instr, err} in a small FIFO, presents the
// head entry first-word-fall-through, stalls fetch when full and discards
// everything on a PC redirect.
module core_ifq #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    input  logic [31:0]   if_pc,
    input  logic [31:0]   if_instr,
    input  logic          if_err,
    input  logic          flush,
    output logic          if_halt,
    output logic          q_valid,
    input  logic          q_ready,
    output logic [31:0]   q_pc,
    output logic [31:0]   q_instr,
    output logic          q_err,
    output logic [AW:0]   q_count
);

    // Major opcode used to present a harmless NOP to decode when empty
    localparam logic [5:0]  OPCODE_NOP = 6'h15;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          err_mem   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Occupancy flags and the qualified push/pop strobes; flush overrides both
    always_comb begin
        full  = (count == FULL_COUNT);
        empty = (count == '0);
        push  = if_valid && !full && !flush;
        pop   = !empty && q_ready && !flush;
    end

    // Stall comes from registered count only, so no ready/valid path reaches fetch
    assign if_halt = full;
    assign q_count = count;

    // Pointer and occupancy bookkeeping; redirect empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage is written only on an accepted push and is never reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= if_pc;
            instr_mem[wr_ptr] <= if_instr;
            err_mem[wr_ptr]   <= if_err;
        end
    end

    // Head entry falls through to decode; an empty queue shows a NOP at pc 0
    always_comb begin
        q_valid = !empty;
        q_pc    = '0;
        q_instr = {OPCODE_NOP, 26'(0)};
        q_err   = 1'b0;
        if (!empty) begin
            q_pc    = pc_mem[rd_ptr];
            q_instr = instr_mem[rd_ptr];
            q_err   = err_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_core_ifq.sv
// Testbench for core_ifq: directed scenarios plus a randomized run checked
// against a queue-based reference model of the fetch queue.
module tb_core_ifq;

    localparam int DEPTH = 4;
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] NOP_WORD = 32'h5400_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } entry_t;

    logic          clk;
    logic          rst;
    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_instr;
    logic          if_err;
    logic          flush;
    logic          if_halt;
    logic          q_valid;
    logic          q_ready;
    logic [31:0]   q_pc;
    logic [31:0]   q_instr;
    logic          q_err;
    logic [AW:0]   q_count;

    int total;
    int bad;
    entry_t mq[$];

    core_ifq #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_err   (if_err),
        .flush    (flush),
        .if_halt  (if_halt),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_pc     (q_pc),
        .q_instr  (q_instr),
        .q_err    (q_err),
        .q_count  (q_count)
    );

    // Free-running core clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the reference model by the current inputs, then clock the DUT
    task automatic step();
        entry_t e;
        bit     do_push;
        bit     do_pop;
        if (flush) begin
            mq.delete();
        end else begin
            do_push = if_valid && (mq.size() < DEPTH);
            do_pop  = q_ready && (mq.size() > 0);
            if (do_pop) begin
                void'(mq.pop_front());
            end
            if (do_push) begin
                e.pc    = if_pc;
                e.instr = if_instr;
                e.err   = if_err;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc, input logic err);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = pc ^ 32'hC0DE_0000;
        if_err   = err;
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0;
        q_ready  = 1'b0;
        flush    = 1'b0;
        if_err   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        if_pc = '0;
        if_instr = '0;
        #3;
        total++;
        if (q_valid !== 1'b0 || q_count !== '0 || if_halt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: valid=%b count=%0d halt=%b required 0/0/0", q_valid, q_count, if_halt);
        end
        total++;
        if (q_instr !== NOP_WORD || q_pc !== 32'h0 || q_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_head: instr=%h pc=%h err=%b required %h/0/0", q_instr, q_pc, q_err, NOP_WORD);
        end
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 0; i < 3; i++) begin
            drive_push(32'hA0 + 32'(4 * i), 1'b0);
            step();
        end
        idle_inputs();
        total++;
        if (q_count !== 3'(3) || q_pc !== 32'hA0) begin
            bad++;
            $display("[TB] FAIL midfill_count: count=%0d pc=%h required 3/000000a0", q_count, q_pc);
        end
        #1;
        rst = 1'b0;
        mq.delete();
        #1;
        total++;
        if (q_valid !== 1'b0 || q_count !== '0 || if_halt !== 1'b0 || q_instr !== NOP_WORD) begin
            bad++;
            $display("[TB] FAIL async_reset: valid=%b count=%0d halt=%b instr=%h required 0/0/0/%h",
                     q_valid, q_count, if_halt, q_instr, NOP_WORD);
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive_push(32'h100, 1'b0);
        total++;
        if (q_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL no_bypass: valid=%b required 0", q_valid);
        end
        step();
        idle_inputs();
        total++;
        if (q_valid !== 1'b1 || q_pc !== 32'h100) begin
            bad++;
            $display("[TB] FAIL push_after_reset: valid=%b pc=%h required 1/00000100", q_valid, q_pc);
        end
        q_ready = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 4; i++) begin
            drive_push(32'(4 * i), 1'b0);
            step();
            total++;
            if (if_halt !== (i == 3)) begin
                bad++;
                $display("[TB] FAIL fill_halt%0d: halt=%b required %b", i, if_halt, (i == 3));
            end
        end
        drive_push(32'h14, 1'b0);
        step();
        idle_inputs();
        total++;
        if (q_count !== 3'(4) || q_pc !== 32'h0 || if_halt !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fifth_ignored: count=%0d pc=%h halt=%b required 4/00000000/1", q_count, q_pc, if_halt);
        end
    endtask

    task automatic test_drain();
        logic [31:0] exp_pc [5];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        q_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i <= 1) begin
                drive_push(32'h10, 1'b0);
            end else begin
                if_valid = 1'b0;
            end
            total++;
            if (q_valid !== 1'b1 || q_pc !== exp_pc[i] || if_halt !== (i == 0)) begin
                bad++;
                $display("[TB] FAIL drain%0d: valid=%b pc=%h halt=%b required 1/%h/%b",
                         i, q_valid, q_pc, if_halt, exp_pc[i], (i == 0));
            end
            step();
        end
        idle_inputs();
        total++;
        if (q_valid !== 1'b0 || q_count !== '0) begin
            bad++;
            $display("[TB] FAIL drain_empty: valid=%b count=%0d required 0/0", q_valid, q_count);
        end
    endtask

    task automatic test_streaming();
        drive_push(32'h300, 1'b0);
        step();
        q_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_push(32'h304 + 32'(4 * i), 1'b0);
            total++;
            if (q_pc !== 32'h300 + 32'(4 * i) || q_count !== 3'(1) || if_halt !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stream%0d: pc=%h count=%0d halt=%b required %h/1/0",
                         i, q_pc, q_count, if_halt, 32'h300 + 32'(4 * i));
            end
            step();
        end
        if_valid = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic test_flush();
        drive_push(32'h500, 1'b0);
        step();
        drive_push(32'h504, 1'b0);
        step();
        drive_push(32'h508, 1'b0);
        q_ready = 1'b1;
        flush = 1'b1;
        step();
        idle_inputs();
        total++;
        if (q_valid !== 1'b0 || q_count !== '0 || if_halt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_clear: valid=%b count=%0d halt=%b required 0/0/0", q_valid, q_count, if_halt);
        end
        drive_push(32'h200, 1'b0);
        step();
        idle_inputs();
        total++;
        if (q_pc !== 32'h200 || q_count !== 3'(1)) begin
            bad++;
            $display("[TB] FAIL flush_next_head: pc=%h count=%0d required 00000200/1", q_pc, q_count);
        end
        q_ready = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_error();
        drive_push(32'h40, 1'b1);
        step();
        drive_push(32'h44, 1'b0);
        step();
        idle_inputs();
        total++;
        if (q_count !== 3'(2)) begin
            bad++;
            $display("[TB] FAIL err_retained: count=%0d required 2", q_count);
        end
        total++;
        if (q_pc !== 32'h40 || q_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL err_first: pc=%h err=%b required 00000040/1", q_pc, q_err);
        end
        q_ready = 1'b1;
        step();
        total++;
        if (q_pc !== 32'h44 || q_err !== 1'b0 || q_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL err_second: pc=%h err=%b valid=%b required 00000044/0/1", q_pc, q_err, q_valid);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_random();
        entry_t      h;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_err;
        for (int i = 0; i < 400; i++) begin
            if_valid = ($urandom_range(0, 3) != 0) && !if_halt;
            if (i % 50 > 30) begin
                if_valid = 1'b1;
            end
            if_pc    = $urandom & 32'hFFFF_FFFC;
            if_instr = $urandom;
            if_err   = ($urandom_range(0, 7) == 0);
            q_ready  = (i % 50 > 30) ? 1'b0 : ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            exp_valid = (mq.size() != 0);
            exp_pc    = 32'h0;
            exp_instr = NOP_WORD;
            exp_err   = 1'b0;
            if (exp_valid) begin
                h = mq[0];
                exp_pc    = h.pc;
                exp_instr = h.instr;
                exp_err   = h.err;
            end
            total++;
            if (q_valid !== exp_valid || q_pc !== exp_pc || q_instr !== exp_instr || q_err !== exp_err ||
                q_count !== (AW + 1)'(mq.size()) || if_halt !== (mq.size() == DEPTH)) begin
                bad++;
                $display("[TB] FAIL random%0d: valid=%b pc=%h instr=%h err=%b count=%0d halt=%b required %b/%h/%h/%b/%0d/%b",
                         i, q_valid, q_pc, q_instr, q_err, q_count, if_halt,
                         exp_valid, exp_pc, exp_instr, exp_err, mq.size(), (mq.size() == DEPTH));
            end
            step();
            if (i == 200) begin
                #1;
                rst = 1'b0;
                mq.delete();
                #1;
                total++;
                if (q_valid !== 1'b0 || q_count !== '0 || if_halt !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL random_reset: valid=%b count=%0d halt=%b required 0/0/0", q_valid, q_count, if_halt);
                end
                #1;
                rst = 1'b1;
            end
        end
        idle_inputs();
    endtask

    // Run all scenarios in sequence and report
    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_reset_mid_fill();
        test_fill_full();
        test_drain();
        test_streaming();
        test_flush();
        test_error();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_ifq.md
Name: core_ifq

Overview:
- Instruction fetch queue between the fetch stage (core_if) and the decode stage.
- Captures each completed fetch {pc, instruction, bus error} into a small FIFO and presents the head entry to decode with a valid/ready handshake.
- Back-pressures fetch via if_halt when full.
- Discards all buffered and in-flight entries on a PC redirect.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
AW, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-low reset
if_valid  input  1  fetch completed this cycle; top level drives it as bus ack AND NOT if_halt
if_pc  input  32  (addr_t) address of the fetched word
if_instr  input  32  (instr_t) fetched instruction
if_err  input  1  bus error on this fetch
flush  input  1  PC redirect; same signal as fetch's set_pc
if_halt  output  1  stall request to fetch
q_valid  output  1  head entry available to decode
q_ready  input  1  decode consumes the head entry this cycle
q_pc  output  32  pc of the head entry
q_instr  output  32  instruction of the head entry
q_err  output  1  error flag of the head entry
q_count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH entries of {pc[31:0], instr[31:0], err}, with a write pointer, a read pointer and a count.
  - Both pointers are AW bits and wrap naturally from DEPTH-1 to 0.
  - count is AW+1 bits.
- push = if_valid AND NOT full AND NOT flush.
- pop = q_valid AND q_ready AND NOT flush.
- full = (count == DEPTH); empty = (count == 0).
- if_halt = full, decoded combinationally from registered count only.
  - There is no path from q_ready or if_valid to if_halt.
  - When full, a pop does not re-enable fetch in the same cycle; a one-cycle bubble is accepted.
  - Fetch qualifies its bus cycle with if_halt in the same cycle, so a fetch is never lost at full.
- Output is first-word-fall-through:
  - q_valid = NOT empty.
  - q_pc, q_instr and q_err come from the entry at the read pointer, combinationally.
  - When empty: q_instr = {OPCODE_NOP, 26'(0)}, q_pc = 0, q_err = 0.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 if the queue was empty. There is no same-cycle bypass.
- Push and pop in the same cycle: the write and read pointers both advance and count is unchanged.
  - Applies at any occupancy between 1 and DEPTH-1.
  - At DEPTH it cannot occur, because push is blocked.
- Pop while empty: impossible, since q_valid = 0; q_ready is ignored.
- Push while full: blocked, since if_halt = 1; if_valid is ignored.
- flush (synchronous, highest priority):
  - On the next edge: write pointer = read pointer = 0, count = 0.
  - if_valid in the same cycle is dropped, because that word is from the stale PC stream.
  - q_ready in the same cycle has no effect on state.
  - Result: q_valid = 0 and if_halt = 0 in the following cycle.
- Error entries are stored and delivered in order like any other entry. The queue does not stop on an error; decode acts on q_err.
- Reset (rst low, asynchronous, any time including mid-operation):
  - Pointers and count go to 0.
  - Outputs: q_valid 0, q_count 0, if_halt 0, q_instr NOP, q_pc 0, q_err 0.
  - Storage contents are not reset and are not observable while empty.
- Data memory is plain registers with no reset; it is written only on push.

Test Plan:
- Reset mid-fill: push 3 entries, pulse rst low → immediately q_valid=0, q_count=0, if_halt=0, q_instr=NOP; after release, the next push of pc 0x100 appears at the head the following cycle.
- Fill to full with q_ready=0: push pcs 0x0, 0x4, 0x8, 0xC → if_halt=1 after the 4th push; a 5th if_valid pulse is ignored; q_pc stays 0x0.
- Drain from full with q_ready=1 and if_valid held high:
  - Pops return 0x0, 0x4, 0x8, 0xC in order.
  - if_halt drops in the cycle after the first pop.
  - The next push (pc 0x10) lands at the wrapped write pointer and is popped 5th.
- Streaming: continuous if_valid and q_ready with count=1 → one entry per cycle in pc order, q_count constant at 1, if_halt never asserted, for 20 cycles across a pointer wrap.
- Flush with a simultaneous push and pop at count=2 → next cycle q_valid=0 and q_count=0; the pushed word is absent; the next push of pc 0x200 is the head.
- Error propagation: push pc 0x40 with if_err=1, then pc 0x44 with if_err=0 → pops deliver q_err=1 then q_err=0, and both entries are retained.
